// File: rtl/frame_deserializer_if.sv
// rtl/frame_deserializer_if.sv - sampler-to-deserializer bit stream and frame result bus
interface frame_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Sampler_sample;
    logic                  Sampler_Sample_Valid;
    logic                  Cfg_par_en;
    logic                  Cfg_par_typ;
    logic [DATA_WIDTH-1:0] Frame_data;
    logic                  Frame_data_valid;
    logic                  Frame_par_err;
    logic                  Frame_stp_err;
    logic                  Frame_busy;

    modport master (
        output Sampler_sample, Sampler_Sample_Valid, Cfg_par_en, Cfg_par_typ,
        input  Frame_data, Frame_data_valid, Frame_par_err, Frame_stp_err, Frame_busy
    );

    modport slave (
        input  Sampler_sample, Sampler_Sample_Valid, Cfg_par_en, Cfg_par_typ,
        output Frame_data, Frame_data_valid, Frame_par_err, Frame_stp_err, Frame_busy
    );
endinterface

// File: rtl/frame_deserializer.sv
// rtl/frame_deserializer.sv - frames voted sampler bits into data words with parity/stop checks
module frame_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 Sampler_CLK,
    input  logic                 Sampler_RST,
    frame_deserializer_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] shift;
    logic [CW-1:0]         count;
    logic                  par_en;
    logic                  par_typ;
    logic                  par_bit;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    logic start;
    logic shift_en;
    logic take_par;
    logic finish;
    logic par_bad;
    logic stp_bad;

    // Parity is checked against the config latched at the start bit, not the live inputs.
    assign par_bad = par_en & (par_bit != ((^shift) ^ par_typ));
    assign stp_bad = ~bus.Sampler_sample;

    // State register; only sampler strobes move it, via next_state.
    always_ff @(posedge Sampler_CLK or negedge Sampler_RST) begin
        if (!Sampler_RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus per-strobe action enables.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        take_par   = 1'b0;
        finish     = 1'b0;
        if (bus.Sampler_Sample_Valid) begin
            case (state)
                IDLE: begin
                    if (!bus.Sampler_sample) begin
                        start      = 1'b1;
                        next_state = DATA;
                    end
                end
                DATA: begin
                    shift_en = 1'b1;
                    if (count == LAST_BIT) begin
                        next_state = par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    take_par   = 1'b1;
                    next_state = STOP;
                end
                STOP: begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath: config latch, LSB-first shift, parity capture and registered frame result.
    always_ff @(posedge Sampler_CLK or negedge Sampler_RST) begin
        if (!Sampler_RST) begin
            shift      <= '0;
            count      <= '0;
            par_en     <= 1'b0;
            par_typ    <= 1'b0;
            par_bit    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (start) begin
                count   <= '0;
                par_en  <= bus.Cfg_par_en;
                par_typ <= bus.Cfg_par_typ;
            end
            if (shift_en) begin
                shift <= {bus.Sampler_sample, shift[DATA_WIDTH-1:1]};
                count <= count + CW'(1);
            end
            if (take_par) begin
                par_bit <= bus.Sampler_sample;
            end
            if (finish) begin
                par_err <= par_bad;
                stp_err <= stp_bad;
                if (!par_bad && !stp_bad) begin
                    data       <= shift;
                    data_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.Frame_data       = data;
    assign bus.Frame_data_valid = data_valid;
    assign bus.Frame_par_err    = par_err;
    assign bus.Frame_stp_err    = stp_err;
    assign bus.Frame_busy       = (state != IDLE);
endmodule

// File: tb/tb_frame_deserializer.sv
// tb/tb_frame_deserializer.sv - directed self-checking bench for frame_deserializer
module tb_frame_deserializer;
    logic clk;
    logic rstn;
    int   checks;
    int   passed;
    int   cyc;
    int   res_cyc;
    logic res_valid;
    logic res_perr;
    logic res_serr;
    logic exp_busy;
    logic [7:0] exp_data;
    int   n_valid;
    int   n_perr;
    int   n_serr;

    frame_deserializer_if #(.DATA_WIDTH(8)) ifc ();

    frame_deserializer #(.DATA_WIDTH(8)) dut (
        .Sampler_CLK (clk),
        .Sampler_RST (rstn),
        .bus         (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Every cycle: outputs must match the frame-level model.
    always @(negedge clk) begin
        check("busy", {31'd0, ifc.Frame_busy}, {31'd0, exp_busy});
        check("data", {24'd0, ifc.Frame_data}, {24'd0, exp_data});
        check("valid", {31'd0, ifc.Frame_data_valid}, {31'd0, (cyc == res_cyc) && res_valid});
        check("par_err", {31'd0, ifc.Frame_par_err}, {31'd0, (cyc == res_cyc) && res_perr});
        check("stp_err", {31'd0, ifc.Frame_stp_err}, {31'd0, (cyc == res_cyc) && res_serr});
        if (ifc.Frame_data_valid) n_valid = n_valid + 1;
        if (ifc.Frame_par_err) n_perr = n_perr + 1;
        if (ifc.Frame_stp_err) n_serr = n_serr + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        ifc.Sampler_sample       = b;
        ifc.Sampler_Sample_Valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.Sampler_Sample_Valid = 1'b0;
    endtask

    // Drives one frame and records what the line semantics say the result must be.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic stp, input logic tog);
        ifc.Cfg_par_en  = pe;
        ifc.Cfg_par_typ = pt;
        strobe(1'b0);
        exp_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            strobe(d[i]);
            if (tog && i == 3) ifc.Cfg_par_en = ~ifc.Cfg_par_en;
        end
        if (pe) begin
            idle(1);
            strobe(pbit);
        end
        idle(1);
        strobe(stp);
        // Total ones over data plus parity bit must be even (typ 0) or odd (typ 1).
        res_perr  = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
        res_serr  = !stp;
        res_valid = !res_perr && !res_serr;
        res_cyc   = cyc;
        exp_busy  = 1'b0;
        if (res_valid) exp_data = d;
    endtask

    initial begin
        checks = 0; passed = 0; cyc = 0; res_cyc = -1;
        res_valid = 0; res_perr = 0; res_serr = 0;
        exp_busy = 0; exp_data = 8'h00;
        n_valid = 0; n_perr = 0; n_serr = 0;
        rstn = 1'b0;
        ifc.Sampler_sample = 1'b1;
        ifc.Sampler_Sample_Valid = 1'b0;
        ifc.Cfg_par_en = 1'b0;
        ifc.Cfg_par_typ = 1'b0;
        #1;
        check("rst_data", {24'd0, ifc.Frame_data}, 32'h0);
        check("rst_busy", {31'd0, ifc.Frame_busy}, 32'h0);
        idle(3);
        rstn = 1'b1;
        idle(2);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("lit_55", {24'd0, ifc.Frame_data}, 32'h55);

        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("lit_a3_even", {24'd0, ifc.Frame_data}, 32'hA3);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("lit_a3_odd", {24'd0, ifc.Frame_data}, 32'hA3);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("lit_hold", {24'd0, ifc.Frame_data}, 32'hA3);

        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
            idle(1);
        end
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("lit_ff", {24'd0, ifc.Frame_data}, 32'hFF);

        ifc.Cfg_par_en = 1'b0;
        strobe(1'b0);
        exp_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            strobe(i[0]);
        end
        rstn = 1'b0;
        exp_busy = 1'b0;
        exp_data = 8'h00;
        res_cyc = -1;
        #1;
        check("midrst_busy", {31'd0, ifc.Frame_busy}, 32'h0);
        check("midrst_data", {24'd0, ifc.Frame_data}, 32'h0);
        check("midrst_valid", {31'd0, ifc.Frame_data_valid}, 32'h0);
        idle(2);
        rstn = 1'b1;
        idle(1);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("lit_12", {24'd0, ifc.Frame_data}, 32'h12);

        send_frame(8'hC5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        check("lit_toggle", {24'd0, ifc.Frame_data}, 32'hC5);

        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("lit_7e", {24'd0, ifc.Frame_data}, 32'h7E);

        check("n_valid", n_valid, 32'd9);
        check("n_par_err", n_perr, 32'd2);
        check("n_stp_err", n_serr, 32'd2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
